mux_obuf: RTL and testbench

- Output flit buffer directly downstream of the 2-1 mux in the router output path.
- Captures the mux output (odata/ovalid/ovch) into a small FIFO and forwards flits to the link under credit-based flow control.
- Checks HEAD/DATA/TAIL packet framing on the incoming stream.
- Exports iready so the upstream arbiter driving the mux sel can stall.

---
 rtl/mux_obuf_pkg.sv | 20 ++
 rtl/obuf_fifo.sv | 49 ++++
 rtl/mux_obuf.sv | 134 +++++++++++++
 tb/tb_mux_obuf.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_obuf_pkg.sv
// Shared definitions for the mux output buffer: flit type codes, default widths
// and the framing-checker state encoding.
package mux_obuf_pkg;

   localparam int DEF_FLITW = 66;
   localparam int DEF_VCW   = 2;

   typedef enum logic [1:0] {
      TYPE_NONE = 2'b00,
      TYPE_HEAD = 2'b01,
      TYPE_DATA = 2'b10,
      TYPE_TAIL = 2'b11
   } flit_type_e;

   typedef enum logic {
      FRM_IDLE = 1'b0,
      FRM_PKT  = 1'b1
   } frm_state_e;

endpackage

// File: rtl/obuf_fifo.sv
// Synchronous FIFO for {vch, flit} entries; the caller must never push when full
// or pop when empty.
module obuf_fifo #(
   parameter int WIDTH = 68,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;

   // NOTE: storage is not reset; pointers and count alone decide what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   assign rdata = mem[rptr];
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/mux_obuf.sv
// Output flit buffer behind the 2-1 mux: FIFO, credit flow control, framing check.
// Define OBUF_STATS_EN to add the flit_cnt/pkt_cnt statistics outputs.
module mux_obuf
   import mux_obuf_pkg::*;
#(
   parameter int FLITW   = DEF_FLITW,
   parameter int VCW     = DEF_VCW,
   parameter int DEPTH   = 4,
   parameter int CREDITS = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [FLITW-1:0] idata,
   input  logic             ivalid,
   input  logic [VCW-1:0]   ivch,
   output logic             iready,
   output logic [FLITW-1:0] odata,
   output logic             ovalid,
   output logic [VCW-1:0]   ovch,
   input  logic             credit_in,
   output logic             ovf_err,
   output logic             frm_err,
   output logic             cred_err
`ifdef OBUF_STATS_EN
   ,
   output logic [31:0]      flit_cnt,
   output logic [31:0]      pkt_cnt
`endif
);

   localparam int ENTRYW = FLITW + VCW;
   localparam int CW     = $clog2(CREDITS + 1);
   localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

   logic [ENTRYW-1:0]       rdata;
   logic                    full, empty, push, pop;
   logic [$clog2(DEPTH):0]  fifo_count;
   logic                    unused_count;
   logic [CW-1:0]           credit;
   flit_type_e              in_type;
   frm_state_e              state, state_nxt;
   logic                    frm_bad;

   assign push    = ivalid && !full;
   assign pop     = !empty && (credit != '0);
   assign iready  = !full;
   assign in_type = flit_type_e'(idata[FLITW-1:FLITW-2]);
   assign unused_count = ^fifo_count;

   obuf_fifo #(.WIDTH(ENTRYW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata ({ivch, idata}),
      .rdata (rdata),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   // NOTE: all state updates use <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         credit   <= CRED_MAX;
         odata    <= '0;
         ovch     <= '0;
         ovalid   <= 1'b0;
         ovf_err  <= 1'b0;
         frm_err  <= 1'b0;
         cred_err <= 1'b0;
      end else begin
         ovalid <= pop;
         if (pop) begin
            odata <= rdata[FLITW-1:0];
            ovch  <= rdata[ENTRYW-1:FLITW];
         end
         if (pop && !credit_in) begin
            credit <= credit - 1'b1;
         end else if (credit_in && !pop) begin
            if (credit == CRED_MAX) cred_err <= 1'b1;
            else                    credit   <= credit + 1'b1;
         end
         if (ivalid && full) ovf_err <= 1'b1;
         if (frm_bad)        frm_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= FRM_IDLE;
      else     state <= state_nxt;
   end

   // NOTE: default assignment first keeps this combinational block latch-free.
   always_comb begin
      state_nxt = state;
      if (push) begin
         case (in_type)
            TYPE_HEAD: state_nxt = FRM_PKT;
            TYPE_TAIL: state_nxt = FRM_IDLE;
            default:   ;
         endcase
      end
   end

   always_comb begin
      frm_bad = 1'b0;
      if (push) begin
         case (in_type)
            TYPE_NONE: frm_bad = 1'b1;
            TYPE_HEAD: frm_bad = (state == FRM_PKT);
            TYPE_DATA: frm_bad = (state == FRM_IDLE);
            TYPE_TAIL: frm_bad = (state == FRM_IDLE);
            default:   frm_bad = 1'b0;
         endcase
      end
   end

`ifdef OBUF_STATS_EN
   flit_type_e head_type;
   assign head_type = flit_type_e'(rdata[FLITW-1:FLITW-2]);

   always_ff @(posedge clk) begin
      if (rst) begin
         flit_cnt <= '0;
         pkt_cnt  <= '0;
      end else if (pop) begin
         flit_cnt <= flit_cnt + 32'd1;
         if (head_type == TYPE_TAIL) pkt_cnt <= pkt_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mux_obuf.sv
// Self-checking bench for mux_obuf: directed sequences, a vector table and
// randomized traffic against a queue-based reference model.
module tb_mux_obuf;

   localparam int FW      = 66;
   localparam int VW      = 2;
   localparam int DEPTH   = 4;
   localparam int CREDITS = 4;
   localparam logic [1:0] T_NONE = 2'b00, T_HEAD = 2'b01, T_DATA = 2'b10, T_TAIL = 2'b11;

   logic          clk = 1'b0;
   logic          rst, ivalid, credit_in;
   logic [FW-1:0] idata;
   logic [VW-1:0] ivch;
   logic          iready, ovalid, ovf_err, frm_err, cred_err;
   logic [FW-1:0] odata;
   logic [VW-1:0] ovch;
`ifdef OBUF_STATS_EN
   logic [31:0]   flit_cnt, pkt_cnt;
`endif

   always #5 clk = ~clk;

   mux_obuf dut (
      .clk       (clk),
      .rst       (rst),
      .idata     (idata),
      .ivalid    (ivalid),
      .ivch      (ivch),
      .iready    (iready),
      .odata     (odata),
      .ovalid    (ovalid),
      .ovch      (ovch),
      .credit_in (credit_in),
      .ovf_err   (ovf_err),
      .frm_err   (frm_err),
      .cred_err  (cred_err)
`ifdef OBUF_STATS_EN
      ,
      .flit_cnt  (flit_cnt),
      .pkt_cnt   (pkt_cnt)
`endif
   );

   int checks   = 0;
   int failures = 0;
   int n_out    = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the buffer is a queue, credits an integer, framing a flag.
   logic [FW+VW-1:0] mq[$];
   int               m_credit;
   logic             m_ovalid, m_ovf, m_frm, m_cred, m_inpkt;
   logic [FW-1:0]    m_odata;
   logic [VW-1:0]    m_ovch;
   int unsigned      m_flits, m_pkts;

   function automatic void model_reset();
      mq.delete();
      m_credit = CREDITS;
      m_ovalid = 1'b0; m_odata = '0; m_ovch = '0;
      m_ovf = 1'b0; m_frm = 1'b0; m_cred = 1'b0; m_inpkt = 1'b0;
      m_flits = 0; m_pkts = 0;
   endfunction

   function automatic void model_step();
      logic [FW+VW-1:0] head;
      logic [1:0]       t;
      bit               do_pop, do_push;
      if (rst) begin
         model_reset();
         return;
      end
      do_pop  = (mq.size() > 0) && (m_credit > 0);
      do_push = ivalid && (mq.size() < DEPTH);
      if (ivalid && !do_push) m_ovf = 1'b1;
      if (do_push) begin
         t = idata[FW-1:FW-2];
         if (t == T_NONE)                        m_frm = 1'b1;
         else if (!m_inpkt && t != T_HEAD)       m_frm = 1'b1;
         else if (m_inpkt && t == T_HEAD)        m_frm = 1'b1;
         if (t == T_HEAD)      m_inpkt = 1'b1;
         else if (t == T_TAIL) m_inpkt = 1'b0;
      end
      if (credit_in && !do_pop && m_credit == CREDITS) m_cred = 1'b1;
      else m_credit = m_credit + int'(credit_in) - int'(do_pop);
      if (do_pop) begin
         head     = mq.pop_front();
         m_ovalid = 1'b1;
         m_odata  = head[FW-1:0];
         m_ovch   = head[FW+VW-1:FW];
         m_flits++;
         if (head[FW-1:FW-2] == T_TAIL) m_pkts++;
      end else begin
         m_ovalid = 1'b0;
      end
      if (do_push) mq.push_back({ivch, idata});
   endfunction

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      check("ovalid", 128'(ovalid), 128'(m_ovalid));
      check("odata", 128'(odata), 128'(m_odata));
      check("ovch", 128'(ovch), 128'(m_ovch));
      check("iready", 128'(iready), 128'(mq.size() < DEPTH));
      check("err_flags", 128'({ovf_err, frm_err, cred_err}), 128'({m_ovf, m_frm, m_cred}));
`ifdef OBUF_STATS_EN
      check("flit_cnt", 128'(flit_cnt), 128'(m_flits));
      check("pkt_cnt", 128'(pkt_cnt), 128'(m_pkts));
`endif
      if (ovalid) n_out++;
   endtask

   task automatic drive(input logic v, input logic [1:0] t, input int p, input logic cr);
      ivalid    = v;
      idata     = {t, 64'(p)};
      ivch      = VW'(p);
      credit_in = cr;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(1'b0, T_NONE, 0, 1'b0);
      step();
      rst = 1'b0;
   endtask

   task automatic send_packet(input int base);
      for (int i = 0; i < 22; i++) begin
         drive(1'b1, (i == 0) ? T_HEAD : (i == 21) ? T_TAIL : T_DATA, base + i, m_ovalid);
         step();
      end
   endtask

   typedef struct {
      logic       v;
      logic [1:0] t;
      logic       cr;
      logic       exp_ovalid;
      logic       exp_iready;
      logic       exp_frm;
      logic       exp_cred;
   } vec_t;

   vec_t tbl[10];
   int   base_out;

   initial begin
      rst = 1'b0;
      drive(1'b0, T_NONE, 0, 1'b0);
      model_reset();

      // Reset state
      do_reset();
      check("rst_ovalid", 128'(ovalid), 128'(0));
      check("rst_odata", 128'(odata), 128'(0));
      check("rst_iready", 128'(iready), 128'(1));
      check("rst_errs", 128'({ovf_err, frm_err, cred_err}), 128'(0));

      // One 22-flit packet, credit returned one cycle after each output
      n_out = 0;
      send_packet(100);
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, T_NONE, 0, m_ovalid);
         step();
      end
      check("pkt_flits_out", 128'(n_out), 128'(22));
      check("pkt_errs", 128'({ovf_err, frm_err, cred_err}), 128'(0));

      // Credit starvation and overflow
      do_reset();
      n_out = 0;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, (i == 0) ? T_HEAD : T_DATA, 200 + i, 1'b0);
         step();
      end
      check("starve_out", 128'(n_out), 128'(4));
      check("starve_iready", 128'(iready), 128'(0));
      drive(1'b1, T_DATA, 208, 1'b0);
      step();
      check("ovf_set", 128'(ovf_err), 128'(1));
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, T_NONE, 0, i < 4);
         step();
      end
      check("refill_out", 128'(n_out), 128'(8));
      check("refill_iready", 128'(iready), 128'(1));

      // Framing and credit-saturation vectors starting from reset
      tbl[0] = '{1'b1, T_DATA, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[1] = '{1'b1, T_HEAD, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[2] = '{1'b1, T_HEAD, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[3] = '{1'b1, T_TAIL, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[4] = '{1'b0, T_NONE, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      tbl[5] = '{1'b0, T_NONE, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[6] = '{1'b0, T_NONE, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[7] = '{1'b0, T_NONE, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[8] = '{1'b0, T_NONE, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      tbl[9] = '{1'b0, T_NONE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      do_reset();
      n_out = 0;
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].v, tbl[i].t, 300 + i, tbl[i].cr);
         step();
         check($sformatf("tbl%0d_ovalid", i), 128'(ovalid), 128'(tbl[i].exp_ovalid));
         check($sformatf("tbl%0d_iready", i), 128'(iready), 128'(tbl[i].exp_iready));
         check($sformatf("tbl%0d_frm", i), 128'(frm_err), 128'(tbl[i].exp_frm));
         check($sformatf("tbl%0d_cred", i), 128'(cred_err), 128'(tbl[i].exp_cred));
      end
      check("frm_flits_fwd", 128'(n_out), 128'(4));
      // Credit stayed at its maximum: exactly CREDITS more flits leave
      base_out = n_out;
      for (int i = 0; i < 8; i++) begin
         drive(i < 5, (i == 0) ? T_HEAD : T_DATA, 400 + i, 1'b0);
         step();
      end
      check("cred_sat_out", 128'(n_out - base_out), 128'(CREDITS));

      // Reset mid-packet with three flits buffered
      do_reset();
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, (i == 0) ? T_HEAD : T_DATA, 500 + i, 1'b0);
         step();
      end
      rst = 1'b1;
      drive(1'b0, T_NONE, 0, 1'b0);
      step();
      rst = 1'b0;
      check("midrst_ovalid", 128'(ovalid), 128'(0));
      check("midrst_iready", 128'(iready), 128'(1));
      n_out = 0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, T_NONE, 0, 1'b0);
         step();
      end
      check("midrst_no_flush", 128'(n_out), 128'(0));
      drive(1'b1, T_HEAD, 600, 1'b0);
      step();
      drive(1'b0, T_NONE, 0, 1'b0);
      step();
      check("midrst_new_flit", 128'({ovalid, odata}), 128'({1'b1, T_HEAD, 64'd600}));

`ifdef OBUF_STATS_EN
      do_reset();
      for (int p = 0; p < 10; p++) send_packet(1000 + 100 * p);
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, T_NONE, 0, m_ovalid);
         step();
      end
      check("stats_flits", 128'(flit_cnt), 128'(220));
      check("stats_pkts", 128'(pkt_cnt), 128'(10));
`endif

      // Randomized traffic with occasional resets
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), int'($urandom),
               ($urandom_range(0, 2) == 0));
         step();
      end
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
